wb_script_master: RTL and testbench

- Synthesizable, parametrised Wishbone classic master that replays a script of transaction entries: writes, reads, masked read-compares and delays.
- Generalises the bench-only address/data write table into reusable RTL with ops, runtime length, ack timeout and error reporting.
- Sits beside the core inside the user project wrapper and drives the MMIO bus to bring up peripherals (timers, GPIO) or run power-on self-test sequences.

---
 rtl/wb_script_master.sv | 188 ++++++++++++++++++
 tb/tb_wb_script_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_script_master.sv
// Wishbone classic master that replays a script of write, read, read-compare
// and delay entries, with an ack timeout and first-error reporting.
module wb_script_master #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned NUM_TRANS   = 8,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned STOP_ON_ERR = 1,
  localparam int unsigned EW = 2 + AW + 2 * DW,
  localparam int unsigned LW = $clog2(NUM_TRANS + 1),
  localparam int unsigned IW = (NUM_TRANS > 1) ? $clog2(NUM_TRANS) : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    start_i,
  input  logic [LW-1:0]           len_i,
  input  logic [NUM_TRANS*EW-1:0] script_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [IW-1:0]           err_idx_o,
  output logic [1:0]              err_code_o,
  output logic                    rd_valid_o,
  output logic [DW-1:0]           rd_data_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [DW/8-1:0]         wbm_sel_o,
  output logic [AW-1:0]           wbm_adr_o,
  output logic [DW-1:0]           wbm_dat_o,
  input  logic                    wbm_ack_i,
  input  logic [DW-1:0]           wbm_dat_i
);

  typedef enum logic [2:0] {IDLE, FETCH, BUS, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_RDCMP, OP_DELAY} op_t;

  state_t        state;
  state_t        adv_state;
  state_t        err_state;
  logic [LW-1:0] idx;
  logic [LW-1:0] len_r;
  logic [LW-1:0] len_eff;
  logic [EW-1:0] entries [NUM_TRANS];
  logic [EW-1:0] cur;
  op_t           op;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [DW-1:0] e_mask;
  logic          cmp_r;
  logic [31:0]   tcnt;
  logic [15:0]   wcnt;
  logic          last;
  logic          cmp_bad;
  logic          tmo;

  // Entry decode, length clamp and next-step decisions
  always_comb begin
    len_eff = (len_i > LW'(NUM_TRANS)) ? LW'(NUM_TRANS) : len_i;
    for (int unsigned i = 0; i < NUM_TRANS; i++) begin
      entries[i] = script_i[(NUM_TRANS-1-i)*EW +: EW];
    end
    cur       = entries[idx[IW-1:0]];
    op        = op_t'(cur[EW-1 -: 2]);
    e_addr    = cur[2*DW +: AW];
    e_data    = cur[DW +: DW];
    e_mask    = cur[DW-1:0];
    last      = ((idx + LW'(1)) == len_r);
    adv_state = last ? DONE : FETCH;
    err_state = (STOP_ON_ERR != 0) ? DONE : adv_state;
    cmp_bad   = cmp_r && ((wbm_dat_i & e_mask) != (e_data & e_mask));
    tmo       = (TIMEOUT != 0) && (tcnt == TIMEOUT - 1);
  end

  // Script sequencer with registered bus and status outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      len_r      <= '0;
      cmp_r      <= 1'b0;
      tcnt       <= '0;
      wcnt       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_idx_o  <= '0;
      err_code_o <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
    end else begin
      done_o     <= 1'b0;
      rd_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_eff != '0) begin
              busy_o     <= 1'b1;
              err_o      <= 1'b0;
              err_idx_o  <= '0;
              err_code_o <= '0;
              idx        <= '0;
              len_r      <= len_eff;
              state      <= FETCH;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        FETCH: begin
          tcnt <= '0;
          if (op == OP_DELAY) begin
            if (e_data[15:0] == 16'd0) begin
              state <= adv_state;
              if (!last) idx <= idx + LW'(1);
            end else begin
              wcnt  <= e_data[15:0];
              state <= WAIT;
            end
          end else begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= '1;
            wbm_we_o  <= (op == OP_WRITE);
            wbm_adr_o <= e_addr;
            wbm_dat_o <= e_data;
            cmp_r     <= (op == OP_RDCMP);
            state     <= BUS;
          end
        end
        BUS: begin
          if (wbm_ack_i || tmo) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            if (!last) idx <= idx + LW'(1);
            if (wbm_ack_i) begin
              if (!wbm_we_o) begin
                rd_data_o  <= wbm_dat_i;
                rd_valid_o <= 1'b1;
              end
              if (cmp_bad) begin
                err_o <= 1'b1;
                if (!err_o) begin
                  err_idx_o  <= idx[IW-1:0];
                  err_code_o <= 2'd1;
                end
                state <= err_state;
              end else begin
                state <= adv_state;
              end
            end else begin
              err_o <= 1'b1;
              if (!err_o) begin
                err_idx_o  <= idx[IW-1:0];
                err_code_o <= 2'd2;
              end
              state <= err_state;
            end
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        WAIT: begin
          wcnt <= wcnt - 16'd1;
          if (wcnt == 16'd1) begin
            state <= adv_state;
            if (!last) idx <= idx + LW'(1);
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_script_master.sv
// Bench for wb_script_master: two instances (abort-on-error and continue-on-error)
// share script/len stimulus; an acking slave model and a script-level reference model.
module tb_wb_script_master;

  localparam int NT = 8;
  localparam int EW = 2 + 32 + 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start [2];
  logic [3:0]       len_i;
  logic [NT*EW-1:0] script;
  logic             busy [2], done [2], err [2], rdv [2];
  logic [2:0]       err_idx [2];
  logic [1:0]       err_code [2];
  logic [31:0]      rd_data [2];
  logic             cyc [2], stb [2], we [2], ack [2];
  logic [3:0]       sel [2];
  logic [31:0]      adr [2], dat_o [2];
  logic             slv_en;
  logic [31:0]      slv_rdata;

  for (genvar g = 0; g < 2; g++) begin : gd
    wb_script_master #(
      .AW(32), .DW(32), .NUM_TRANS(NT), .TIMEOUT(8), .STOP_ON_ERR(g == 0 ? 1 : 0)
    ) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start[g]), .len_i(len_i), .script_i(script),
      .busy_o(busy[g]), .done_o(done[g]), .err_o(err[g]), .err_idx_o(err_idx[g]),
      .err_code_o(err_code[g]), .rd_valid_o(rdv[g]), .rd_data_o(rd_data[g]),
      .wbm_cyc_o(cyc[g]), .wbm_stb_o(stb[g]), .wbm_we_o(we[g]), .wbm_sel_o(sel[g]),
      .wbm_adr_o(adr[g]), .wbm_dat_o(dat_o[g]), .wbm_ack_i(ack[g]), .wbm_dat_i(slv_rdata)
    );
  end

  // Slave: single ack one cycle after stb, only when enabled
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) ack[g] <= 1'b0;
      else     ack[g] <= slv_en && cyc[g] && stb[g] && !ack[g];
    end
  end

  // Bus/status monitor
  int          n_txn [2], n_rdv [2], n_done [2], n_rise [2], n_badsel [2], n_busy [2];
  int          max_run [2], run_c [2], low_c [2], rise_gap [2];
  logic        cyc_q [2];
  logic        t_we [2][16];
  logic [31:0] t_adr [2][16], t_dat [2][16];
  int          t_gap [2][16];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cyc[g] && !cyc_q[g]) begin
        n_rise[g]   <= n_rise[g] + 1;
        rise_gap[g] <= low_c[g];
      end
      if (cyc[g]) begin
        run_c[g] <= run_c[g] + 1;
        if (run_c[g] + 1 > max_run[g]) max_run[g] <= run_c[g] + 1;
        low_c[g] <= 0;
      end else begin
        run_c[g] <= 0;
        low_c[g] <= low_c[g] + 1;
      end
      cyc_q[g] <= cyc[g];
      if (cyc[g] && stb[g] && ack[g]) begin
        if (n_txn[g] < 16) begin
          t_we[g][n_txn[g]]  <= we[g];
          t_adr[g][n_txn[g]] <= adr[g];
          t_dat[g][n_txn[g]] <= dat_o[g];
          t_gap[g][n_txn[g]] <= rise_gap[g];
        end
        n_txn[g] <= n_txn[g] + 1;
        if (sel[g] !== 4'hF) n_badsel[g] <= n_badsel[g] + 1;
      end
      if (rdv[g])  n_rdv[g]  <= n_rdv[g] + 1;
      if (done[g]) n_done[g] <= n_done[g] + 1;
      if (busy[g]) n_busy[g] <= n_busy[g] + 1;
    end
  end

  // Script and reference model state
  logic [1:0]  s_op [NT];
  logic [31:0] s_adr [NT], s_dat [NT], s_msk [NT];
  int          e_n [2], e_rdv [2];
  logic        e_we [2][16];
  logic [31:0] e_adr [2][16], e_dat [2][16];
  logic [31:0] m_rdata [2];
  logic        m_err [2];
  logic [2:0]  m_idx [2];
  logic [1:0]  m_code [2];

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NT; i++) script[(NT-1-i)*EW +: EW] = {s_op[i], s_adr[i], s_dat[i], s_msk[i]};
  endtask

  task automatic set_entry(input int i, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] m);
    s_op[i] = op; s_adr[i] = a; s_dat[i] = d; s_msk[i] = m;
  endtask

  task automatic clear_script();
    for (int i = 0; i < NT; i++) set_entry(i, 2'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic random_script();
    for (int i = 0; i < NT; i++) begin
      s_op[i]  = 2'($urandom_range(0, 3));
      s_adr[i] = $urandom;
      s_msk[i] = $urandom;
      s_dat[i] = (s_op[i] == 2'd3) ? 32'($urandom_range(0, 4)) : $urandom;
      if (s_op[i] == 2'd2 && $urandom_range(0, 1) == 1)
        s_dat[i] = (slv_rdata & s_msk[i]) | (~s_msk[i] & $urandom);
    end
    pack();
  endtask

  // Script-level model: which bus transfers happen and what status results
  task automatic model(input int g, input int len);
    int l;
    l = (len > NT) ? NT : len;
    e_n[g] = 0;
    e_rdv[g] = 0;
    if (l > 0) begin m_err[g] = 1'b0; m_code[g] = 2'd0; m_idx[g] = 3'd0; end
    for (int i = 0; i < l; i++) begin
      int code;
      code = 0;
      if (s_op[i] == 2'd3) continue;
      if (!slv_en) code = 2;
      else begin
        if (e_n[g] < 16) begin
          e_we[g][e_n[g]] = (s_op[i] == 2'd0);
          e_adr[g][e_n[g]] = s_adr[i];
          e_dat[g][e_n[g]] = s_dat[i];
        end
        e_n[g]++;
        if (s_op[i] != 2'd0) begin e_rdv[g]++; m_rdata[g] = slv_rdata; end
        if (s_op[i] == 2'd2 && ((slv_rdata & s_msk[i]) != (s_dat[i] & s_msk[i]))) code = 1;
      end
      if (code != 0) begin
        if (!m_err[g]) begin m_idx[g] = 3'(i); m_code[g] = 2'(code); end
        m_err[g] = 1'b1;
        if (g == 0) break;
      end
    end
  endtask

  task automatic clear_mon();
    for (int g = 0; g < 2; g++) begin
      n_txn[g] = 0; n_rdv[g] = 0; n_done[g] = 0; n_rise[g] = 0; n_badsel[g] = 0;
      n_busy[g] = 0; max_run[g] = 0; run_c[g] = 0; low_c[g] = 0; rise_gap[g] = 0;
    end
  endtask

  task automatic run(input int len, input bit s0, input bit s1, input int extra_at);
    clear_mon();
    @(negedge clk);
    len_i = 4'(len); start[0] = s0; start[1] = s1;
    @(negedge clk);
    start[0] = 1'b0; start[1] = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (c == extra_at) begin start[0] = s0; start[1] = s1; end
      else begin start[0] = 1'b0; start[1] = 1'b0; end
      if (c > extra_at && (!s0 || n_done[0] > 0) && (!s1 || n_done[1] > 0)) break;
      @(negedge clk);
    end
    start[0] = 1'b0; start[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("finish_bound", 64'((!s0 || n_done[0] > 0) && (!s1 || n_done[1] > 0)), 64'd1);
  endtask

  task automatic check_run(input int g, input string name);
    check($sformatf("%s%0d/done_pulses", name, g), 64'(n_done[g]), 64'd1);
    check($sformatf("%s%0d/ntxn", name, g), 64'(n_txn[g]), 64'(e_n[g]));
    for (int i = 0; i < e_n[g] && i < n_txn[g] && i < 16; i++) begin
      check($sformatf("%s%0d/txn%0d_adr_dat", name, g, i), {t_adr[g][i], t_dat[g][i]},
            {e_adr[g][i], e_dat[g][i]});
      check($sformatf("%s%0d/txn%0d_we", name, g, i), 64'(t_we[g][i]), 64'(e_we[g][i]));
    end
    check($sformatf("%s%0d/rd_valid_pulses", name, g), 64'(n_rdv[g]), 64'(e_rdv[g]));
    check($sformatf("%s%0d/rd_data", name, g), 64'(rd_data[g]), 64'(m_rdata[g]));
    check($sformatf("%s%0d/err", name, g), 64'(err[g]), 64'(m_err[g]));
    check($sformatf("%s%0d/err_code", name, g), 64'(err_code[g]), 64'(m_code[g]));
    check($sformatf("%s%0d/err_idx", name, g), 64'(err_idx[g]), 64'(m_idx[g]));
    check($sformatf("%s%0d/bad_sel", name, g), 64'(n_badsel[g]), 64'd0);
    check($sformatf("%s%0d/busy_end", name, g), 64'(busy[g]), 64'd0);
  endtask

  task automatic check_reset(input string name);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s%0d/ctrl", name, g),
            64'({busy[g], done[g], err[g], rdv[g], cyc[g], stb[g], we[g], sel[g]}), 64'd0);
      check($sformatf("%s%0d/adr_dat", name, g), {adr[g], dat_o[g]}, 64'd0);
      check($sformatf("%s%0d/rd_err", name, g), 64'({rd_data[g], err_idx[g], err_code[g]}), 64'd0);
      m_rdata[g] = '0; m_err[g] = 1'b0; m_idx[g] = '0; m_code[g] = '0;
    end
  endtask

  initial begin
    rst = 1'b1; start[0] = 1'b0; start[1] = 1'b0; len_i = '0; script = '0;
    slv_en = 1'b1; slv_rdata = '0;
    clear_script(); pack(); clear_mon();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Fixed write table
    clear_script();
    set_entry(0, 2'd0, 32'h0000_FF00, 32'h0000_CA00, 32'h0);
    set_entry(1, 2'd0, 32'h0000_CA84, 32'hFFFF_FFFF, 32'h0);
    set_entry(2, 2'd0, 32'h0000_CAA4, 32'h0000_0010, 32'h0);
    set_entry(3, 2'd0, 32'h0000_CAA0, 32'h0000_0049, 32'h0);
    set_entry(4, 2'd0, 32'hFFFF_0000, 32'hCAFE_BABE, 32'h0);
    pack(); model(0, 5); model(1, 5);
    run(5, 1, 1, -1);
    check_run(0, "write"); check_run(1, "write");
    check("write/last_adr_dat", {t_adr[0][4], t_dat[0][4]}, 64'hFFFF_0000_CAFE_BABE);

    // Read and masked compares
    slv_rdata = 32'h1234_5678;
    clear_script();
    set_entry(0, 2'd1, 32'h10, 32'h0, 32'h0);
    set_entry(1, 2'd2, 32'h10, 32'h0000_5678, 32'h0000_FFFF);
    set_entry(2, 2'd2, 32'h10, 32'h0000_5679, 32'h0000_FFFF);
    pack(); model(0, 3); model(1, 3);
    run(3, 1, 1, -1);
    check_run(0, "rdcmp"); check_run(1, "rdcmp");
    check("rdcmp/code_idx", 64'({err_code[0], err_idx[0]}), 64'({2'd1, 3'd2}));

    // Ack timeout
    slv_en = 1'b0;
    clear_script();
    set_entry(0, 2'd0, 32'h20, 32'hA5A5_0001, 32'h0);
    set_entry(1, 2'd0, 32'h24, 32'hA5A5_0002, 32'h0);
    set_entry(2, 2'd1, 32'h28, 32'h0, 32'h0);
    pack(); model(0, 3); model(1, 3);
    run(3, 1, 1, -1);
    check_run(0, "timeout"); check_run(1, "timeout");
    check("timeout/cyc_cycles", 64'(max_run[0]), 64'd8);
    check("timeout/cyc_rises", 64'(n_rise[0]), 64'd1);
    check("timeout/cyc_rises_nostop", 64'(n_rise[1]), 64'd3);
    slv_en = 1'b1;

    // Delay between two writes
    clear_script();
    set_entry(0, 2'd0, 32'h30, $urandom, 32'h0);
    set_entry(1, 2'd3, 32'h0, 32'd5, 32'h0);
    set_entry(2, 2'd0, 32'h34, $urandom, 32'h0);
    pack(); model(0, 3); model(1, 3);
    run(3, 1, 1, -1);
    check_run(0, "delay");
    check("delay/gap_ge5", 64'(t_gap[0][1] >= 5), 64'd1);

    // Zero length
    model(0, 0); model(1, 0);
    run(0, 1, 1, -1);
    check_run(0, "len0");
    check("len0/no_cyc", 64'(n_rise[0]), 64'd0);
    check("len0/no_busy", 64'(n_busy[0]), 64'd0);

    // Over-long length clamps to NUM_TRANS
    slv_rdata = $urandom;
    random_script(); model(0, NT + 3); model(1, NT + 3);
    run(NT + 3, 1, 1, -1);
    check_run(0, "clamp"); check_run(1, "clamp");

    // Continue-on-error vs abort-on-error
    slv_rdata = $urandom;
    clear_script();
    set_entry(0, 2'd0, 32'h40, $urandom, 32'h0);
    set_entry(1, 2'd2, 32'h44, ~slv_rdata, 32'hFFFF_FFFF);
    set_entry(2, 2'd0, 32'h48, $urandom, 32'h0);
    pack(); model(0, 3); model(1, 3);
    run(3, 1, 1, -1);
    check_run(0, "stoperr"); check_run(1, "stoperr");
    check("stoperr/nostop_txn_idx", 64'({n_txn[1], 29'd0, err_idx[1]}), 64'({32'd3, 29'd0, 3'd1}));

    // Randomised scripts
    for (int r = 0; r < 6; r++) begin
      int l;
      slv_rdata = $urandom;
      l = $urandom_range(0, NT + 3);
      random_script(); model(0, l); model(1, l);
      run(l, 1, 1, -1);
      check_run(0, $sformatf("rand%0d_", r)); check_run(1, $sformatf("rand%0d_", r));
    end

    // Start pulse while busy (continue-on-error instance only)
    slv_rdata = $urandom;
    clear_script();
    set_entry(0, 2'd2, 32'h50, ~slv_rdata, 32'hFFFF_FFFF);
    set_entry(1, 2'd3, 32'h0, 32'd20, 32'h0);
    set_entry(2, 2'd0, 32'h54, $urandom, 32'h0);
    pack(); model(1, 3);
    run(3, 0, 1, 8);
    check_run(1, "busystart");
    check("busystart/other_idle", 64'(n_rise[0]), 64'd0);

    // Reset during a bus cycle, then rerun from entry 0
    slv_en = 1'b0;
    random_script();
    s_op[0] = 2'd0; pack();
    @(negedge clk);
    len_i = 4'd3; start[0] = 1'b1; start[1] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; start[1] = 1'b0;
    for (int c = 0; c < 20 && !cyc[0]; c++) @(negedge clk);
    @(negedge clk);
    check("midbus/cyc_before_reset", 64'(cyc[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midbus_reset");
    rst = 1'b0;
    slv_en = 1'b1;
    slv_rdata = $urandom;
    model(0, 3); model(1, 3);
    run(3, 1, 1, -1);
    check_run(0, "after_reset"); check_run(1, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
